// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clk_hz, input int unsigned baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  // master: the receiver itself; slave: whoever drives the line and consumes bytes
  modport master (input rx, output rx_data, output rx_valid, output rx_frame_err, output rx_busy);
  modport slave  (output rx, input rx_data, input rx_valid, input rx_frame_err, input rx_busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized line, 3-sample majority vote, mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK = 27000000,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  bus
);
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(INPUT_CLOCK, BAUD_RATE);
  localparam int unsigned HALF_BIT     = half_bit(INPUT_CLOCK, BAUD_RATE);
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  logic [2:0]       hist_q, hist_d;
  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sample;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign sample = majority3(hist_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    hist_d    = {hist_q[1:0], rx_s};

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is not still low at mid-bit is treated as a glitch
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {sample, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= 3'b111;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = err_q;
  assign bus.rx_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] last_good = 8'h00;
  exp_t exp_q[$];

  uart_rx_if bus ();

  uart_rx #(.INPUT_CLOCK(160), .BAUD_RATE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_bit(input logic v, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      bus.rx = (glitch && i == CPB / 2 - 1) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Reference model: a good stop bit delivers the byte, a bad one flags an error
  // and leaves the previously delivered byte in place.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit glitch);
    exp_t e;
    e.fall   = cyc;
    e.is_err = !stop_ok;
    if (stop_ok) last_good = d;
    e.data = last_good;
    exp_q.push_back(e);
    $display("frame data=%02h stop_ok=%0b glitch=%0b start_cycle=%0d", d, stop_ok, glitch, cyc);
    drive_bit(1'b0, CPB, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(d[b], CPB, glitch);
    drive_bit(stop_ok, CPB, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse
  initial begin
    exp_t e;
    int   lat;
    logic prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pulse = 1'b0;
      end else begin
        if (prev_pulse) check("pulse_width", int'(bus.rx_valid | bus.rx_frame_err), 0);
        if (bus.rx_valid || bus.rx_frame_err) begin
          check("valid_err_exclusive", int'(bus.rx_valid & bus.rx_frame_err), 0);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%02h at cycle %0d, expected no pulse",
                     bus.rx_valid, bus.rx_frame_err, bus.rx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind_err", int'(bus.rx_frame_err), int'(e.is_err));
            check("rx_data", int'(bus.rx_data), int'(e.data));
            lat = cyc - e.fall;
            checks++;
            if (lat >= LAT - 1 && lat <= LAT + 1) passes++;
            else $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT);
          end
        end
        prev_pulse = bus.rx_valid | bus.rx_frame_err;
      end
    end
  end

  initial begin
    logic [7:0] aa;
    logic [7:0] d;
    bit ok;
    bit g;
    aa = 8'hAA;
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", int'(bus.rx_data), 0);
    check("reset_rx_valid", int'(bus.rx_valid), 0);
    check("reset_rx_frame_err", int'(bus.rx_frame_err), 0);
    check("reset_rx_busy", int'(bus.rx_busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(bus.rx_busy), 0);

    // Bad stop bit, line held low (break), then a good frame
    send_frame(8'h31, 1'b0, 1'b0);
    drive_bit(1'b0, 40, 1'b0);
    check("break_busy", int'(bus.rx_busy), 1);
    drive_bit(1'b1, 20, 1'b0);
    check("after_break_busy", int'(bus.rx_busy), 0);
    check("after_break_data", int'(bus.rx_data), 0);
    send_frame(8'h36, 1'b1, 1'b0);
    drive_bit(1'b1, 20, 1'b0);

    send_frame(8'h35, 1'b1, 1'b0);
    drive_bit(1'b1, 20, 1'b0);

    // Short low glitch must be rejected
    drive_bit(1'b0, 3, 1'b0);
    drive_bit(1'b1, 2, 1'b0);
    check("glitch_busy_mid", int'(bus.rx_busy), 1);
    drive_bit(1'b1, 7, 1'b0);
    check("glitch_busy_end", int'(bus.rx_busy), 0);
    drive_bit(1'b1, 20, 1'b0);

    // Back-to-back frames with no idle time
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h36, 1'b1, 1'b0);
    drive_bit(1'b1, 20, 1'b0);

    // Reset during data bit 4 of 0xAA abandons the frame
    $display("partial frame data=aa aborted by rst at cycle %0d", cyc + 4 * CPB + CPB + 8);
    drive_bit(1'b0, CPB, 1'b0);
    for (int b = 0; b < 4; b++) drive_bit(aa[b], CPB, 1'b0);
    drive_bit(aa[4], 8, 1'b0);
    check("pre_rst_busy", int'(bus.rx_busy), 1);
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    check("post_rst_data", int'(bus.rx_data), 0);
    check("post_rst_busy", int'(bus.rx_busy), 0);
    drive_bit(1'b1, 40, 1'b0);
    check("post_rst_idle_data", int'(bus.rx_data), 0);
    send_frame(8'h55, 1'b1, 1'b0);
    drive_bit(1'b1, 20, 1'b0);

    // Mid-bit single-cycle glitches filtered by majority vote
    send_frame(8'h0F, 1'b1, 1'b1);
    drive_bit(1'b1, 20, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      g  = 1'($urandom_range(0, 1));
      send_frame(d, ok, g);
      if (!ok) begin
        drive_bit(1'b0, $urandom_range(0, 30), 1'b0);
        drive_bit(1'b1, $urandom_range(1, 10), 1'b0);
      end else begin
        drive_bit(1'b1, $urandom_range(0, 12), 1'b0);
      end
    end
    drive_bit(1'b1, 20, 1'b0);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("missing_pulses", exp_q.size(), 0);
    check("final_busy", int'(bus.rx_busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
